file_1109_837: RTL and testbench
================================

FILE_1109_837 -- requirements
Module: file_1109_837

Interface
REQ-001 Parameters: none; all widths fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 a  input  4  operand A; two's-complement signed for ans1 and ans3, plain bit vector for ans2.
REQ-005 b  input  4  operand B; unsigned shift amount for ans1/ans2, two's-complement signed addend for ans3.
REQ-006 ans1  output  4  arithmetic right shift of a by b; combinational.
REQ-007 ans2  output  4  logical right shift of a by b; combinational.
REQ-008 ans3  output  4  registered signed sum of a and b.

Function
REQ-009 ans1 SHALL equal signed(a) >>> unsigned(b), with vacated MSBs filled with a[3].
REQ-010 For b >= 4, ans1 SHALL be 4'b1111 if a[3]=1, else 4'b0000.
REQ-011 ans2 SHALL equal a >> unsigned(b), with vacated MSBs filled with 0.
REQ-012 For b >= 4, ans2 SHALL be 4'b0000.
REQ-013 ans1 and ans2 SHALL respond to input changes with zero cycle latency and no dependence on clk or reset.
REQ-014 ans3 SHALL update on every rising clk edge with reset=0 to the 4-bit signed sum of a and b; latency 1 cycle.
REQ-015 The sum SHALL be computed at 5 bits internally (sign-extended operands); overflow handling per REQ-019/REQ-020.
REQ-016 ans3 SHALL hold its value between rising edges regardless of input changes.

Reset
REQ-017 When reset=1 at a rising clk edge, ans3 SHALL become 4'b0000; reset SHALL take priority over the sum update.
REQ-018 Reset SHALL NOT affect ans1 or ans2. Before the first edge with reset=1, ans3 is unspecified.

Configuration
REQ-019 With macro FILE_1109_837_SAT_EN defined, ans3 SHALL saturate: results above +7 SHALL become 4'b0111; results below -8 SHALL become 4'b1000.
REQ-020 Without FILE_1109_837_SAT_EN, ans3 SHALL be the low 4 bits of the sum (two's-complement wrap).

Verification
REQ-021 a=3, b=1 -> ans1=4'b0001, ans2=4'b0001 immediately; after one clk edge, ans3=4'b0100.
REQ-022 a=-2 (4'b1110), b=1 -> ans1=4'b1111, ans2=4'b0111; after one edge, ans3=4'b1111.
REQ-023 a=4'b1000, b=5 -> ans1=4'b1111, ans2=4'b0000; a=4'b0110, b=4 -> ans1=4'b0000, ans2=4'b0000.
REQ-024 a=7, b=1, one edge -> ans3=4'b0111 with FILE_1109_837_SAT_EN; ans3=4'b1000 without.
REQ-025 a=-8, b=-1, one edge -> ans3=4'b1000 with FILE_1109_837_SAT_EN; ans3=4'b0111 without.
REQ-026 Sequence:
- ans3 nonzero, then reset=1 with a=3, b=1 for one edge -> ans3=4'b0000.
- ans1 and ans2 unchanged throughout (4'b0001, 4'b0001).
- Deassert reset -> next edge gives ans3=4'b0100.

Source files
------------

// File: rtl/file_1109_837.sv
// 4-bit shifter/adder: combinational arithmetic and logical right shifts, plus a registered signed sum.
// Optional macro FILE_1109_837_SAT_EN makes the registered sum saturate instead of wrapping.
module file_1109_837 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] ans1,
  output logic [3:0] ans2,
  output logic [3:0] ans3
);

  logic [4:0] sum_w;
  logic [3:0] ans3_d, ans3_q;

  // Shift amounts of 4 or more fully vacate the operand, leaving only fill bits.
  assign ans1 = $signed(a) >>> b;
  assign ans2 = a >> b;

  assign sum_w = {a[3], a} + {b[3], b};

  always_comb begin
    ans3_d = sum_w[3:0];
`ifdef FILE_1109_837_SAT_EN
    // Overflow shows as a disagreement between the 5-bit sign and the 4-bit sign.
    if (sum_w[4] != sum_w[3])
      ans3_d = sum_w[4] ? 4'b1000 : 4'b0111;
`else
    ans3_d = sum_w[3:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) ans3_q <= 4'b0000;
    else       ans3_q <= ans3_d;
  end

  assign ans3 = ans3_q;

endmodule

// File: tb/tb_file_1109_837.sv
// Directed self-checking bench for file_1109_837; expectations follow the build's saturation macro.
module tb_file_1109_837;

  logic       clk;
  logic       reset;
  logic [3:0] a, b;
  logic [3:0] ans1, ans2, ans3;

  int checks = 0;
  int errors = 0;

  file_1109_837 dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .ans1 (ans1),
    .ans2 (ans2),
    .ans3 (ans3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; a = 4'd5; b = 4'd2;
    tick();
    checks++;
    if (ans3 !== 4'b0000) begin
      errors++; $display("FAIL reset_ans3 got %b exp %b", ans3, 4'b0000);
    end
    tick();
    checks++;
    if (ans3 !== 4'b0000) begin
      errors++; $display("FAIL reset_priority got %b exp %b", ans3, 4'b0000);
    end
    reset = 1'b0;
  endtask

  task automatic test_shift();
    logic [3:0] va [8];
    logic [3:0] vb [8];
    logic [3:0] e1 [8];
    logic [3:0] e2 [8];
    va = '{4'b0011, 4'b1110, 4'b1000, 4'b0110, 4'b1011, 4'b1001, 4'b1000, 4'b0111};
    vb = '{4'd1,    4'd1,    4'd5,    4'd4,    4'd2,    4'd0,    4'd3,    4'd15};
    e1 = '{4'b0001, 4'b1111, 4'b1111, 4'b0000, 4'b1110, 4'b1001, 4'b1111, 4'b0000};
    e2 = '{4'b0001, 4'b0111, 4'b0000, 4'b0000, 4'b0010, 4'b1001, 4'b0001, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      a = va[i]; b = vb[i];
      #1;
      checks++;
      if (ans1 !== e1[i]) begin
        errors++; $display("FAIL shift_ans1[%0d] a=%b b=%0d got %b exp %b", i, a, b, ans1, e1[i]);
      end
      checks++;
      if (ans2 !== e2[i]) begin
        errors++; $display("FAIL shift_ans2[%0d] a=%b b=%0d got %b exp %b", i, a, b, ans2, e2[i]);
      end
    end
  endtask

  task automatic test_sum();
    logic [3:0] va [6];
    logic [3:0] vb [6];
    logic [3:0] ex [6];
    va = '{4'd3,    4'b1110, 4'd5,    4'b1100, 4'd7,    4'b1000};
    vb = '{4'd1,    4'd1,    4'b1101, 4'b1100, 4'd1,    4'b1111};
`ifdef FILE_1109_837_SAT_EN
    ex = '{4'b0100, 4'b1111, 4'b0010, 4'b1000, 4'b0111, 4'b1000};
`else
    ex = '{4'b0100, 4'b1111, 4'b0010, 4'b1000, 4'b1000, 4'b0111};
`endif
    for (int i = 0; i < 6; i++) begin
      a = va[i]; b = vb[i];
      tick();
      checks++;
      if (ans3 !== ex[i]) begin
        errors++; $display("FAIL sum[%0d] a=%b b=%b got %b exp %b", i, va[i], vb[i], ans3, ex[i]);
      end
    end
  endtask

  task automatic test_hold();
    a = 4'd2; b = 4'd3;
    tick();
    a = 4'd6; b = 4'd1;
    #2;
    checks++;
    if (ans3 !== 4'b0101) begin
      errors++; $display("FAIL hold got %b exp %b", ans3, 4'b0101);
    end
    tick();
    checks++;
    if (ans3 !== 4'b0111) begin
      errors++; $display("FAIL hold_update got %b exp %b", ans3, 4'b0111);
    end
  endtask

  task automatic test_reset_seq();
    a = 4'd5; b = 4'd2;
    tick();
    checks++;
    if (ans3 !== 4'b0111) begin
      errors++; $display("FAIL seq_pre got %b exp %b", ans3, 4'b0111);
    end
    reset = 1'b1; a = 4'd3; b = 4'd1;
    #1;
    checks++;
    if (ans1 !== 4'b0001 || ans2 !== 4'b0001) begin
      errors++; $display("FAIL seq_shift_in_reset got %b/%b exp 0001/0001", ans1, ans2);
    end
    tick();
    checks++;
    if (ans3 !== 4'b0000) begin
      errors++; $display("FAIL seq_reset got %b exp %b", ans3, 4'b0000);
    end
    checks++;
    if (ans1 !== 4'b0001 || ans2 !== 4'b0001) begin
      errors++; $display("FAIL seq_shift_after_reset got %b/%b exp 0001/0001", ans1, ans2);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ans3 !== 4'b0100) begin
      errors++; $display("FAIL seq_release got %b exp %b", ans3, 4'b0100);
    end
  endtask

  initial begin
    reset = 1'b0; a = 4'd0; b = 4'd0;
    #2;
    test_reset();
    test_shift();
    test_sum();
    test_hold();
    test_reset_seq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
